// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file_sb register file slice.
// Optional feature macro used by the top: RF_BYPASS_EN (same-cycle write forwarding).
package reg_file_pkg;

    localparam int RF_ADDR_W_DEF = 4;
    localparam int RF_WIDTH_DEF  = 32;
    localparam int RF_CNT_W      = 8;
    localparam logic [RF_CNT_W-1:0] RF_CNT_MAX = 8'hFF;

    typedef logic [RF_ADDR_W_DEF-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a load issues,
// cleared by any accepted write. A set in the same cycle as a clear wins,
// because it represents a newer load. With ZERO_R0 the R0 bit is held at 0.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W  = RF_ADDR_W_DEF,
    parameter int ZERO_R0 = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_a_en,
    input  logic [ADDR_W-1:0]    clr_a_addr,
    input  logic                 clr_b_en,
    input  logic [ADDR_W-1:0]    clr_b_addr,
    input  logic                 set_en,
    input  logic [ADDR_W-1:0]    set_addr,
    output logic [2**ADDR_W-1:0] sb_vec
);

    logic [2**ADDR_W-1:0] sb_nxt;

    // Next scoreboard value: clears first, then the set, then R0 masking.
    always_comb begin
        sb_nxt = sb_vec;
        if (clr_a_en) sb_nxt[clr_a_addr] = 1'b0;
        if (clr_b_en) sb_nxt[clr_b_addr] = 1'b0;
        if (set_en)   sb_nxt[set_addr]   = 1'b1;
        if (ZERO_R0 != 0) sb_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb_vec <= '0;
        else        sb_vec <= sb_nxt;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two write ports (A has priority), NRD combinational read
// ports, pending-write scoreboard and a saturating write-collision counter.
// Optional macro RF_BYPASS_EN: reads forward data from writes accepted this cycle.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int ADDR_W  = RF_ADDR_W_DEF,
    parameter int WIDTH   = RF_WIDTH_DEF,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*WIDTH-1:0]    rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic                    wa_en,
    input  logic [ADDR_W-1:0]       wa_addr,
    input  logic [WIDTH-1:0]        wa_data,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    sb_set,
    input  logic [ADDR_W-1:0]       sb_addr,
    output logic [2**ADDR_W-1:0]    sb_vec,
    output logic                    wr_conflict,
    output logic [RF_CNT_W-1:0]     conflict_cnt
);

    localparam int NREG = 2**ADDR_W;
    localparam bit Z0   = (ZERO_R0 != 0);

    logic [WIDTH-1:0] mem [NREG];
    logic collision;
    logic wb_acc;
    logic wa_wr;
    logic wb_wr;

    // Port A always wins a same-address collision; R0 writes are dropped when hardwired.
    always_comb begin
        collision = wa_en && wb_en && (wa_addr == wb_addr);
        wb_acc    = wb_en && !collision;
        wa_wr     = wa_en  && !(Z0 && (wa_addr == '0));
        wb_wr     = wb_acc && !(Z0 && (wb_addr == '0));
    end

    // Data array; accepted writes never target the same entry, so order is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            if (wb_wr) mem[wb_addr] <= wb_data;
            if (wa_wr) mem[wa_addr] <= wa_data;
        end
    end

    // Collision pulse and saturating collision count (R0 collisions still count).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_conflict  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            wr_conflict <= collision;
            if (collision && (conflict_cnt != RF_CNT_MAX))
                conflict_cnt <= conflict_cnt + RF_CNT_W'(1);
        end
    end

    reg_file_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_a_en   (wa_en),
        .clr_a_addr (wa_addr),
        .clr_b_en   (wb_acc),
        .clr_b_addr (wb_addr),
        .set_en     (sb_set),
        .set_addr   (sb_addr),
        .sb_vec     (sb_vec)
    );

    // Read muxes; with forwarding, a write accepted this cycle overrides the array (A over B)
    // and reports not-busy, since the scoreboard only reflects a same-cycle set after the edge.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [ADDR_W-1:0] ra;
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            rd_data[k*WIDTH +: WIDTH] = mem[ra];
            rd_busy[k]                = sb_vec[ra];
`ifdef RF_BYPASS_EN
            if (wb_wr && (wb_addr == ra)) begin
                rd_data[k*WIDTH +: WIDTH] = wb_data;
                rd_busy[k]                = 1'b0;
            end
            if (wa_wr && (wa_addr == ra)) begin
                rd_data[k*WIDTH +: WIDTH] = wa_data;
                rd_busy[k]                = 1'b0;
            end
`endif
            if (Z0 && (ra == '0)) begin
                rd_data[k*WIDTH +: WIDTH] = '0;
                rd_busy[k]                = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with ordinary R0, one with hardwired R0,
// both driven by the same stimulus. Expected values follow RF_BYPASS_EN when defined.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        wa_en = 1'b0, wb_en = 1'b0, sb_set = 1'b0;
    logic [3:0]  wa_addr = '0, wb_addr = '0, sb_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;

    logic [63:0] rd_data,  rd_data_z;
    logic [1:0]  rd_busy,  rd_busy_z;
    logic [15:0] sb_vec,   sb_vec_z;
    logic        wr_conflict, wr_conflict_z;
    logic [7:0]  conflict_cnt, conflict_cnt_z;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.ADDR_W(4), .WIDTH(32), .NRD(2), .ZERO_R0(0)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_vec(sb_vec),
        .wr_conflict(wr_conflict), .conflict_cnt(conflict_cnt)
    );

    reg_file_sb #(.ADDR_W(4), .WIDTH(32), .NRD(2), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_vec(sb_vec_z),
        .wr_conflict(wr_conflict_z), .conflict_cnt(conflict_cnt_z)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; sb_set = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (rd_data !== 64'h0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else n_pass++;
        n_total++; if (sb_vec !== 16'h0) $display("FAIL reset_sb_vec got %h exp 0", sb_vec); else n_pass++;
        n_total++; if ({wr_conflict, conflict_cnt} !== 9'h0) $display("FAIL reset_conflict got %b/%h exp 0/0", wr_conflict, conflict_cnt); else n_pass++;
        #4 rst_n = 1'b1;
        step();
        rd_addr = 8'h03;
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'hDEADBEEF;
        sb_set = 1'b1; sb_addr = 4'd3;
        step();
        idle();
        #1;
        n_total++; if (rd_data[31:0] !== 32'hDEADBEEF) $display("FAIL write_r3 got %h exp deadbeef", rd_data[31:0]); else n_pass++;
        n_total++; if (sb_vec[3] !== 1'b1) $display("FAIL sb_r3_set got %b exp 1", sb_vec[3]); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (rd_data[31:0] !== 32'h0) $display("FAIL async_reset_r3 got %h exp 0", rd_data[31:0]); else n_pass++;
        n_total++; if (sb_vec !== 16'h0) $display("FAIL async_reset_sb got %h exp 0", sb_vec); else n_pass++;
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'h1234;
        step();
        idle();
        #1 rst_n = 1'b1;
        #1;
        n_total++; if (rd_data[31:0] !== 32'h0) $display("FAIL write_during_reset got %h exp 0", rd_data[31:0]); else n_pass++;
    endtask

    task automatic test_collision();
        step();
        rd_addr = 8'h98;
        wa_en = 1'b1; wa_addr = 4'd8; wa_data = 32'hAAAA;
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'hBBBB;
        step();
        idle();
        #1;
        n_total++; if (rd_data !== 64'h0000BBBB_0000AAAA) $display("FAIL dual_write got %h exp 0000bbbb0000aaaa", rd_data); else n_pass++;
        n_total++; if (wr_conflict !== 1'b0) $display("FAIL no_conflict got %b exp 0", wr_conflict); else n_pass++;
        rd_addr = 8'h05;
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'h1111;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h2222;
        step();
        idle();
        #1;
        n_total++; if (rd_data[31:0] !== 32'h1111) $display("FAIL collision_data got %h exp 1111", rd_data[31:0]); else n_pass++;
        n_total++; if (wr_conflict !== 1'b1) $display("FAIL conflict_pulse got %b exp 1", wr_conflict); else n_pass++;
        n_total++; if (conflict_cnt !== 8'd1) $display("FAIL conflict_cnt1 got %0d exp 1", conflict_cnt); else n_pass++;
        step();
        n_total++; if (wr_conflict !== 1'b0) $display("FAIL conflict_pulse_end got %b exp 0", wr_conflict); else n_pass++;
        n_total++; if (conflict_cnt !== 8'd1) $display("FAIL conflict_cnt_hold got %0d exp 1", conflict_cnt); else n_pass++;
    endtask

    task automatic test_scoreboard();
        rd_addr = 8'h70;
        sb_set = 1'b1; sb_addr = 4'd7;
        step();
        idle();
        #1;
        n_total++; if (rd_busy[1] !== 1'b1) $display("FAIL busy_r7 got %b exp 1", rd_busy[1]); else n_pass++;
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h55;
        step();
        idle();
        #1;
        n_total++; if (rd_busy[1] !== 1'b0) $display("FAIL busy_r7_clear got %b exp 0", rd_busy[1]); else n_pass++;
        n_total++; if (rd_data[63:32] !== 32'h55) $display("FAIL load_r7 got %h exp 55", rd_data[63:32]); else n_pass++;
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h66;
        sb_set = 1'b1; sb_addr = 4'd7;
        step();
        idle();
        #1;
        n_total++; if (sb_vec[7] !== 1'b1) $display("FAIL set_wins_r7 got %b exp 1", sb_vec[7]); else n_pass++;
        n_total++; if (rd_data[63:32] !== 32'h66) $display("FAIL load2_r7 got %h exp 66", rd_data[63:32]); else n_pass++;
        wa_en = 1'b1; wa_addr = 4'd7; wa_data = 32'h77;
        step();
        idle();
        #1;
        n_total++; if (sb_vec !== 16'h0) $display("FAIL a_clears_r7 got %h exp 0", sb_vec); else n_pass++;
    endtask

    task automatic test_zero_r0();
        rd_addr = 8'h00;
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 4'd0;
        step();
        idle();
        #1;
        n_total++; if (rd_data[31:0] !== 32'hFFFFFFFF) $display("FAIL r0_ordinary got %h exp ffffffff", rd_data[31:0]); else n_pass++;
        n_total++; if (sb_vec[0] !== 1'b1) $display("FAIL r0_ordinary_sb got %b exp 1", sb_vec[0]); else n_pass++;
        n_total++; if (rd_data_z[31:0] !== 32'h0) $display("FAIL r0_zero got %h exp 0", rd_data_z[31:0]); else n_pass++;
        n_total++; if ({sb_vec_z[0], rd_busy_z[0]} !== 2'b00) $display("FAIL r0_zero_sb got %b exp 00", {sb_vec_z[0], rd_busy_z[0]}); else n_pass++;
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 32'hFFFFFFFF;
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'h3;
        step();
        idle();
        #1;
        n_total++; if (conflict_cnt_z !== 8'd2) $display("FAIL r0_conflict_cnt got %0d exp 2", conflict_cnt_z); else n_pass++;
        n_total++; if (rd_data_z[31:0] !== 32'h0) $display("FAIL r0_zero_after_conflict got %h exp 0", rd_data_z[31:0]); else n_pass++;
    endtask

    task automatic test_saturation();
        rd_addr = 8'h09;
        for (int i = 0; i < 300; i++) begin
            wa_en = 1'b1; wa_addr = 4'd9; wa_data = 32'(i);
            wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'hFFFF;
            step();
            if (i == 99) begin
                n_total++; if (conflict_cnt !== 8'd102) $display("FAIL sat_mid got %0d exp 102", conflict_cnt); else n_pass++;
            end
        end
        idle();
        #1;
        n_total++; if (conflict_cnt !== 8'hFF) $display("FAIL sat_cnt got %h exp ff", conflict_cnt); else n_pass++;
        n_total++; if (conflict_cnt_z !== 8'hFF) $display("FAIL sat_cnt_z got %h exp ff", conflict_cnt_z); else n_pass++;
        n_total++; if (rd_data[31:0] !== 32'd299) $display("FAIL sat_last_data got %h exp 12b", rd_data[31:0]); else n_pass++;
        step();
        n_total++; if ({wr_conflict, conflict_cnt} !== 9'h0FF) $display("FAIL sat_hold got %b/%h exp 0/ff", wr_conflict, conflict_cnt); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] exp_a, exp_b;
        logic        exp_busy;
`ifdef RF_BYPASS_EN
        exp_a = 32'hA5A5; exp_b = 32'hCCCC; exp_busy = 1'b0;
`else
        exp_a = 32'h1234; exp_b = 32'h0;    exp_busy = 1'b1;
`endif
        rd_addr = 8'h42;
        wa_en = 1'b1; wa_addr = 4'd2; wa_data = 32'h1234;
        sb_set = 1'b1; sb_addr = 4'd2;
        step();
        idle();
        sb_set = 1'b1; sb_addr = 4'd2;
        step();
        idle();
        #1;
        n_total++; if (rd_busy[0] !== 1'b1) $display("FAIL bypass_pre_busy got %b exp 1", rd_busy[0]); else n_pass++;
        wa_en = 1'b1; wa_addr = 4'd2; wa_data = 32'hA5A5;
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'hCCCC;
        #1;
        n_total++; if (rd_data[31:0] !== exp_a) $display("FAIL bypass_a got %h exp %h", rd_data[31:0], exp_a); else n_pass++;
        n_total++; if (rd_busy[0] !== exp_busy) $display("FAIL bypass_busy got %b exp %b", rd_busy[0], exp_busy); else n_pass++;
        n_total++; if (rd_data[63:32] !== exp_b) $display("FAIL bypass_b got %h exp %h", rd_data[63:32], exp_b); else n_pass++;
        step();
        idle();
        #1;
        n_total++; if (rd_data !== 64'h0000CCCC_0000A5A5) $display("FAIL post_bypass got %h exp 0000cccc0000a5a5", rd_data); else n_pass++;
        n_total++; if (rd_busy[0] !== 1'b0) $display("FAIL post_bypass_busy got %b exp 0", rd_busy[0]); else n_pass++;
        rd_addr = 8'h00;
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 32'h1;
        #1;
        n_total++; if (rd_data_z[31:0] !== 32'h0) $display("FAIL r0_no_bypass got %h exp 0", rd_data_z[31:0]); else n_pass++;
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_collision();
        test_scoreboard();
        test_zero_r0();
        test_saturation();
        test_bypass();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
